// File: rtl/frame_dump_controller.sv
// rtl/frame_dump_controller.sv - streams a LENGTH x WIDTH frame from image memory once luma and chroma planes are both done
module frame_dump_controller #(
    parameter int  LENGTH = 64,
    parameter int  WIDTH  = 64,
    localparam int N      = LENGTH * WIDTH,
    localparam int AW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          luma_done,
    input  logic          chroma_done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_last,
    output logic          busy,
    output logic          write_done,
    output logic [15:0]   frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    localparam logic [AW:0] N_C    = (AW+1)'(N);
    localparam logic [AW:0] LAST_C = (AW+1)'(N - 1);

    state_t      state_q, state_d;
    logic        luma_q, luma_d, chroma_q, chroma_d;
    logic [AW:0] rd_cnt_q, rd_cnt_d;
    logic        inflight_q, inflight_d, inflight_last_q, inflight_last_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [8:0]  e0_q, e0_d, e1_q, e1_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        start, pop;
    logic [2:0]  occ;
    logic [1:0]  slot;

    assign start = (state_q == S_IDLE) && en && luma_q && chroma_q;
    assign pop   = (cnt_q != 2'd0) && pix_ready;
    // Occupancy the FIFO will reach once the read already in flight lands.
    assign occ   = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
    assign slot  = cnt_q - {1'b0, pop};

    assign rd_en      = (state_q == S_STREAM) && (rd_cnt_q < N_C) && (occ < 3'd2);
    assign rd_addr    = (rd_cnt_q < N_C) ? rd_cnt_q[AW-1:0] : AW'(N - 1);
    assign pix_valid  = (cnt_q != 2'd0);
    assign pix_data   = pix_valid ? e0_q[7:0] : 8'h00;
    assign pix_last   = pix_valid && e0_q[8];
    assign busy       = (state_q != S_IDLE);
    assign write_done = (state_q == S_DONE);
    assign frame_cnt  = frame_cnt_q;

    always_comb begin
        state_d         = state_q;
        luma_d          = luma_q | luma_done;
        chroma_d        = chroma_q | chroma_done;
        rd_cnt_d        = rd_cnt_q + (AW+1)'(rd_en);
        inflight_d      = rd_en;
        inflight_last_d = rd_en && (rd_cnt_q == LAST_C);
        frame_cnt_d     = frame_cnt_q;
        e0_d            = pop ? e1_q : e0_q;
        e1_d            = e1_q;
        cnt_d           = cnt_q - {1'b0, pop} + {1'b0, inflight_q};

        if (inflight_q) begin
            if (slot == 2'd0) begin
                e0_d = {inflight_last_q, rd_data};
            end else begin
                e1_d = {inflight_last_q, rd_data};
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_STREAM;
                    luma_d     = luma_done;
                    chroma_d   = chroma_done;
                    rd_cnt_d   = '0;
                    cnt_d      = 2'd0;
                    inflight_d = 1'b0;
                end
            end
            S_STREAM: begin
                if (pop && e0_q[8]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                frame_cnt_d = frame_cnt_q + 16'd1;
                rd_cnt_d    = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            luma_q          <= 1'b0;
            chroma_q        <= 1'b0;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            cnt_q           <= 2'd0;
            e0_q            <= 9'd0;
            e1_q            <= 9'd0;
            frame_cnt_q     <= 16'd0;
        end else begin
            state_q         <= state_d;
            luma_q          <= luma_d;
            chroma_q        <= chroma_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            cnt_q           <= cnt_d;
            e0_q            <= e0_d;
            e1_q            <= e1_d;
            frame_cnt_q     <= frame_cnt_d;
        end
    end

endmodule

// File: doc/frame_dump_controller.md
FRAME_DUMP_CONTROLLER -- requirements
Module: frame_dump_controller

Interface
REQ-001 Parameter LENGTH, default 64, image rows.
REQ-002 Parameter WIDTH, default 64, image columns; N = LENGTH*WIDTH pixels, AW = $clog2(N).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  level enable, frame start permitted only while high.
REQ-006 luma_done  input  1  single-cycle or level event, luma plane of current frame complete.
REQ-007 chroma_done  input  1  single-cycle or level event, chroma plane complete.
REQ-008 rd_en  output  1  image memory read strobe.
REQ-009 rd_addr  output  AW  image memory read address, raster order.
REQ-010 rd_data  input  8  memory read data, valid exactly one cycle after rd_en.
REQ-011 pix_data  output  8  streamed pixel.
REQ-012 pix_valid  output  1  pix_data valid.
REQ-013 pix_ready  input  1  downstream accepts; beat transfers when pix_valid && pix_ready.
REQ-014 pix_last  output  1  high with the beat for address N-1.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 write_done  output  1  single-cycle pulse, frame fully transferred.
REQ-017 frame_cnt  output  16  completed frames, wraps 0xFFFF->0x0000.

Function
REQ-018 Sticky flags luma_seen/chroma_seen set on any cycle luma_done/chroma_done is high, in any state.
REQ-019 FSM states IDLE, STREAM, DONE.
REQ-020 IDLE->STREAM when en && luma_seen && chroma_seen; both flags cleared on that edge unless the corresponding input is high in that same cycle (set wins).
REQ-021 Done events during STREAM/DONE are held in flags for the next frame; never lost, never trigger mid-frame.
REQ-022 On entering STREAM: read address counter=0, beat counter=0, FIFO empty, no read in flight.
REQ-023 Output buffer is a 2-entry FIFO; pix_valid = FIFO non-empty; pix_data/pix_last = FIFO head.
REQ-024 rd_en high in STREAM iff read counter < N and (FIFO count - pop_this_cycle + in_flight) < 2; rd_addr = read counter, incremented when rd_en.
REQ-025 in_flight = rd_en of previous cycle; rd_data pushed into FIFO in that cycle with last tag = (address was N-1).
REQ-026 Throughput: with pix_ready held high, one beat per cycle sustained.
REQ-027 Latency: start condition true in cycle t -> rd_en addr 0 at t+1 -> pix_valid at t+3.
REQ-028 Backpressure: pix_data/pix_last stable while pix_valid && !pix_ready; no FIFO overflow, no dropped or duplicated beat.
REQ-029 STREAM->DONE on the edge following the handshake of the pix_last beat.
REQ-030 DONE lasts exactly one cycle: write_done=1, frame_cnt increments; next state IDLE.
REQ-031 Back-to-back: if flags set and en high in IDLE after DONE, STREAM re-entered next cycle.
REQ-032 en deassert during STREAM/DONE does not abort; frame completes, then IDLE holds until en.
REQ-033 rd_en never asserted outside STREAM; rd_addr never exceeds N-1.

Reset
REQ-034 rst high at a clock edge, in any state including mid-frame: state=IDLE, flags=0, counters=0, FIFO empty, in_flight=0.
REQ-035 Outputs during/after reset: rd_en=0, rd_addr=0, pix_valid=0, pix_last=0, pix_data=0, busy=0, write_done=0, frame_cnt=0.
REQ-036 rd_data returning after a mid-frame reset is discarded.

Verification
REQ-037 LENGTH=WIDTH=4, memory[i]=i, en=1, luma_done then chroma_done pulses 3 cycles apart, pix_ready=1 -> 16 beats 0x00..0x0F on consecutive cycles, pix_last on 0x0F only, write_done one cycle later, frame_cnt=1.
REQ-038 Same, pix_ready toggled pseudo-randomly -> identical beat sequence, data stable while stalled, FIFO never exceeds 2.
REQ-039 Both done pulses with en=0 for 10 cycles, then en=1 -> stream begins; rd_en addr 0 one cycle after en rises.
REQ-040 New luma_done+chroma_done during frame 1 -> frame 2 starts cycle after DONE, no extra pulses needed; frame_cnt=2.
REQ-041 rst asserted at beat 7 -> all outputs at reset values next cycle; restart yields full frame from address 0.
REQ-042 Only luma_done pulsed -> no rd_en ever, busy stays 0.
